// File: rtl/updn_counter_param.sv
// rtl/updn_counter_param.sv - parametrised up/down counter with load, wrap/tc flags and sticky overflow
// Define UPDN_CNT_SATURATE_EN to saturate at the boundaries instead of wrapping.
module updn_counter_param #(
  parameter int              WIDTH = 5,
  parameter logic [WIDTH-1:0] MAXV  = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap,
  output logic             ovf
);

  logic [WIDTH-1:0] out_q, out_d;
  logic             wrap_q, wrap_d;
  logic             ovf_q, ovf_d;
  logic             at_bound;

  always_comb begin
    out_d    = out_q;
    wrap_d   = 1'b0;
    ovf_d    = ovf_q & ~clr_ovf;
    at_bound = up ? (out_q == MAXV) : (out_q == '0);
    if (load) begin
      out_d = (load_val > MAXV) ? MAXV : load_val;
    end else if (en) begin
      if (!at_bound) begin
        out_d = up ? out_q + 1'b1 : out_q - 1'b1;
      end else begin
        // A crossing sets ovf even when clr_ovf is asserted on the same edge.
        ovf_d = 1'b1;
`ifdef UPDN_CNT_SATURATE_EN
        out_d = out_q;
`else
        out_d  = up ? '0 : MAXV;
        wrap_d = 1'b1;
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q  <= INIT;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out  = out_q;
  assign wrap = wrap_q;
  assign ovf  = ovf_q;
  assign tc   = up ? (out_q == MAXV) : (out_q == '0);

endmodule
